// File: rtl/div_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl_if
// Bundle of every non-clock/reset signal around the divide issue controller.
//   Pipeline side : ex_valid, inst_opcode, rs1_data, rs2_data, flush (to ctrl)
//                   div_stall, wb_valid, wb_data, div_err (from ctrl)
//   Divider side  : div_ready, div_dividend, div_diviser, div_opcode (from ctrl)
//                   div_rem_data, div_finish (to ctrl)
// master = the controller, slave = its environment (pipeline + divider).
// ---------------------------------------------------------------------------
interface div_issue_ctrl_if;
    logic        ex_valid;
    logic [7:0]  inst_opcode;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        div_stall;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic        div_err;
    logic        div_ready;
    logic [63:0] div_dividend;
    logic [63:0] div_diviser;
    logic [7:0]  div_opcode;
    logic [63:0] div_rem_data;
    logic        div_finish;

    modport master (
        input  ex_valid, inst_opcode, rs1_data, rs2_data, flush,
        input  div_rem_data, div_finish,
        output div_stall, wb_valid, wb_data, div_err,
        output div_ready, div_dividend, div_diviser, div_opcode
    );

    modport slave (
        output ex_valid, inst_opcode, rs1_data, rs2_data, flush,
        output div_rem_data, div_finish,
        input  div_stall, wb_valid, wb_data, div_err,
        input  div_ready, div_dividend, div_diviser, div_opcode
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
// Execute-stage requester for the iterative divider. Accepts the eight
// DIV/REM opcodes, prepares operands, answers divide-by-zero and signed
// overflow locally, otherwise requests the divider, waits for its result,
// formats it and presents it to writeback. Stalls the pipeline while busy.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - div_issue_ctrl_if.master (pipeline request/writeback + divider)
// Parameters:
//   TIMEOUT - WAIT/DRAIN cycles before the outstanding divide is abandoned
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int TIMEOUT = 96
) (
    input  logic             clk,
    input  logic             rst,
    div_issue_ctrl_if.master bus
);
    localparam logic [7:0] OP_DIV   = 8'h30;
    localparam logic [7:0] OP_DIVU  = 8'h31;
    localparam logic [7:0] OP_REM   = 8'h32;
    localparam logic [7:0] OP_REMU  = 8'h33;
    localparam logic [7:0] OP_DIVW  = 8'h34;
    localparam logic [7:0] OP_DIVUW = 8'h35;
    localparam logic [7:0] OP_REMW  = 8'h36;
    localparam logic [7:0] OP_REMUW = 8'h37;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_DONE  = 5'b01000,
        S_DRAIN = 5'b10000
    } state_e;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] prep_operand(input logic [63:0] x,
                                                 input logic        w,
                                                 input logic        sgn);
        if (!w)
            return x;
        else if (sgn)
            return sext32(x[31:0]);
        else
            return {32'b0, x[31:0]};
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      dividend_q, dividend_d;
    logic [63:0]      divisor_q, divisor_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [63:0]      wb_data_q, wb_data_d;
    logic             err_q, err_d;

    logic        is_div, is_w, is_sgn, is_rem, lat_w;
    logic [63:0] dividend_p, divisor_p, special_res;
    logic        div_zero, ovf, accept;
    logic        stall_c, wb_valid_c, ready_c;

    always_comb begin
        is_div = 1'b1;
        is_w   = 1'b0;
        is_sgn = 1'b0;
        is_rem = 1'b0;
        case (bus.inst_opcode)
            OP_DIV:   is_sgn = 1'b1;
            OP_DIVU:  ;
            OP_REM:   begin is_sgn = 1'b1; is_rem = 1'b1; end
            OP_REMU:  is_rem = 1'b1;
            OP_DIVW:  begin is_w = 1'b1; is_sgn = 1'b1; end
            OP_DIVUW: is_w = 1'b1;
            OP_REMW:  begin is_w = 1'b1; is_sgn = 1'b1; is_rem = 1'b1; end
            OP_REMUW: begin is_w = 1'b1; is_rem = 1'b1; end
            default:  is_div = 1'b0;
        endcase
    end

    assign lat_w = (opcode_q == OP_DIVW) || (opcode_q == OP_DIVUW) ||
                   (opcode_q == OP_REMW) || (opcode_q == OP_REMUW);

    assign dividend_p = prep_operand(bus.rs1_data, is_w, is_sgn);
    assign divisor_p  = prep_operand(bus.rs2_data, is_w, is_sgn);
    assign div_zero   = (divisor_p == 64'd0);
    assign ovf = is_sgn && (is_w ?
                 (bus.rs1_data[31:0] == 32'h8000_0000 && bus.rs2_data[31:0] == 32'hFFFF_FFFF) :
                 (bus.rs1_data == 64'h8000_0000_0000_0000 && bus.rs2_data == {64{1'b1}}));

    // Locally resolved results; remainder by zero returns the dividend
    // re-extended from its low word for W ops (also for REMUW).
    always_comb begin
        special_res = 64'd0;
        if (div_zero)
            special_res = is_rem ? (is_w ? sext32(bus.rs1_data[31:0]) : bus.rs1_data)
                                 : {64{1'b1}};
        else if (!is_rem)
            special_res = is_w ? sext32(32'h8000_0000) : 64'h8000_0000_0000_0000;
    end

    // rst gating keeps div_stall low while reset is held.
    assign accept = rst && bus.ex_valid && is_div && !bus.flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        opcode_d   = opcode_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;
        stall_c    = 1'b0;
        wb_valid_c = 1'b0;
        ready_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    dividend_d = dividend_p;
                    divisor_d  = divisor_p;
                    opcode_d   = bus.inst_opcode;
                    err_d      = 1'b0;
                    if (div_zero || ovf) begin
                        wb_data_d = special_res;
                        state_d   = S_DONE;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                ready_c = 1'b1;
                stall_c = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus.div_finish) begin
                    wb_data_d = lat_w ? sext32(bus.div_rem_data[31:0]) : bus.div_rem_data;
                    state_d   = S_DONE;
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    wb_data_d = 64'd0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DRAIN: begin
                // The divider cannot be cancelled; swallow its result.
                stall_c = bus.ex_valid && is_div;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus.div_finish || cnt_q >= CNT_LAST)
                    state_d = S_IDLE;
            end
            S_DONE: begin
                stall_c    = bus.ex_valid && is_div;
                wb_valid_c = !bus.flush;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dividend_q <= 64'd0;
            divisor_q  <= 64'd0;
            opcode_q   <= 8'd0;
            wb_data_q  <= 64'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            opcode_q   <= opcode_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.div_stall    = stall_c;
    assign bus.wb_valid     = wb_valid_c;
    assign bus.wb_data      = wb_data_q;
    assign bus.div_err      = err_q;
    assign bus.div_ready    = ready_c;
    assign bus.div_dividend = dividend_q;
    assign bus.div_diviser  = divisor_q;
    assign bus.div_opcode   = opcode_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
// Scoreboard bench: each op that should reach writeback pushes its expected
// {data, err}; a negedge monitor pops and compares on every wb_valid.
// A behavioural divider answers div_ready after model_lat cycles with
// model_res (or never, when model_hang is set).
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;
    localparam int TIMEOUT = 96;
    localparam logic [7:0] OP_DIV   = 8'h30;
    localparam logic [7:0] OP_DIVU  = 8'h31;
    localparam logic [7:0] OP_REM   = 8'h32;
    localparam logic [7:0] OP_REMU  = 8'h33;
    localparam logic [7:0] OP_DIVW  = 8'h34;
    localparam logic [7:0] OP_DIVUW = 8'h35;
    localparam logic [7:0] OP_REMW  = 8'h36;
    localparam logic [7:0] OP_REMUW = 8'h37;
    localparam logic [63:0] ONES    = {64{1'b1}};

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_issue_ctrl_if bus();
    div_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ready_cnt = 0;
    int          rdy_cyc = 0;
    int          fin_cyc = 0;
    int          wb_cyc = 0;
    logic [63:0] cap_a = 64'd0;
    logic [63:0] cap_b = 64'd0;
    logic        model_hang = 1'b0;
    int          model_lat = 5;
    logic [63:0] model_res = 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider
    initial begin
        bus.div_finish   = 1'b0;
        bus.div_rem_data = 64'd0;
        forever begin
            @(negedge clk);
            if (bus.div_ready === 1'b1) begin
                ready_cnt++;
                rdy_cyc = cyc;
                cap_a   = bus.div_dividend;
                cap_b   = bus.div_diviser;
                if (!model_hang) begin
                    repeat (model_lat) @(negedge clk);
                    bus.div_finish   = 1'b1;
                    bus.div_rem_data = model_res;
                    fin_cyc          = cyc;
                    @(negedge clk);
                    bus.div_finish   = 1'b0;
                end
            end
        end
    end

    // Writeback monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.wb_valid === 1'b1) begin
            wb_cyc = cyc;
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'(bus.wb_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("wb_data", bus.wb_data, e.data);
                check("wb_err", 64'(bus.div_err), 64'(e.err));
            end
        end
    end

    task automatic push_exp(input logic [63:0] d, input logic err);
        exp_t t;
        t.data = d;
        t.err  = err;
        sb.push_back(t);
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        @(posedge clk); #1;
        bus.ex_valid    = 1'b1;
        bus.inst_opcode = op;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk); #1;
        end
        if (sb.size() != 0) begin
            check("sb_wait_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // One complete op from an idle controller. Special ops must answer at
    // T+1 without div_ready; normal ops must request exactly once.
    task automatic run_op(input string name, input logic [7:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit special, input logic [63:0] exp_data, input logic exp_err,
                          input logic [63:0] exp_a, input logic [63:0] exp_b);
        int r0 = ready_cnt;
        push_exp(exp_data, exp_err);
        drive_op(op, a, b);
        @(negedge clk);
        check({name, "_stall_accept"}, 64'(bus.div_stall), 64'(!special));
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        if (special)
            check({name, "_wb_latency"}, 64'(bus.wb_valid), 64'd1);
        else
            check({name, "_ready_latency"}, 64'(bus.div_ready), 64'd1);
        wait_sb_empty(400);
        @(negedge clk);
        check({name, "_ready_count"}, 64'(ready_cnt - r0), 64'(!special));
        if (!special) begin
            check({name, "_dividend"}, cap_a, exp_a);
            check({name, "_divisor"}, cap_b, exp_b);
            if (exp_err)
                check({name, "_timeout_cycles"}, 64'(wb_cyc - rdy_cyc), 64'(TIMEOUT + 1));
            else
                check({name, "_finish_to_wb"}, 64'(wb_cyc - fin_cyc), 64'd1);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        rst             = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.inst_opcode = 8'd0;
        bus.rs1_data    = 64'd0;
        bus.rs2_data    = 64'd0;
        bus.flush       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", 64'(bus.div_stall), 64'd0);
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_ready", 64'(bus.div_ready), 64'd0);
        check("rst_err", 64'(bus.div_err), 64'd0);
        check("rst_wb_data", bus.wb_data, 64'd0);
        check("rst_dividend", bus.div_dividend, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Normal divides
        model_lat = 5;
        model_res = 64'd14;
        run_op("divu", OP_DIVU, 64'd100, 64'd7, 0, 64'd14, 1'b0, 64'd100, 64'd7);
        model_res = 64'hFFFF_FFFF_FFFF_FFF2;
        run_op("div_neg", OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0,
               64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        model_res = 64'h0000_0000_FFFF_FFFF;
        run_op("remw", OP_REMW, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 0,
               ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        model_res = 64'h0000_0000_0FFF_FFFF;
        run_op("divuw", OP_DIVUW, 64'hABCD_0000_FFFF_FFF0, 64'h1111_0000_0000_0010, 0,
               64'h0000_0000_0FFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFF0, 64'h10);
        model_res = 64'h0000_0000_0000_0000;
        run_op("divu_noovf", OP_DIVU, 64'h8000_0000_0000_0000, ONES, 0,
               64'd0, 1'b0, 64'h8000_0000_0000_0000, ONES);

        // Locally resolved cases
        run_op("div_by0", OP_DIV, 64'd5, 64'd0, 1, ONES, 1'b0, 64'd0, 64'd0);
        run_op("rem_by0", OP_REM, 64'd5, 64'd0, 1, 64'd5, 1'b0, 64'd0, 64'd0);
        run_op("remw_by0", OP_REMW, 64'h1234_5678_8000_0005, 64'hFFFF_0000_0000_0000, 1,
               64'hFFFF_FFFF_8000_0005, 1'b0, 64'd0, 64'd0);
        run_op("remuw_by0", OP_REMUW, 64'h1234_5678_8000_0005, 64'd0, 1,
               64'hFFFF_FFFF_8000_0005, 1'b0, 64'd0, 64'd0);
        run_op("divuw_by0", OP_DIVUW, 64'd9, 64'h5555_0000_0000_0000, 1, ONES, 1'b0, 64'd0, 64'd0);
        run_op("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 1,
               64'hFFFF_FFFF_8000_0000, 1'b0, 64'd0, 64'd0);
        run_op("remw_ovf", OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'd0, 1'b0, 64'd0, 64'd0);
        run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, ONES, 1,
               64'h8000_0000_0000_0000, 1'b0, 64'd0, 64'd0);
        run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, ONES, 1, 64'd0, 1'b0, 64'd0, 64'd0);

        // Non-divide opcode is ignored
        r0 = ready_cnt;
        drive_op(8'h01, 64'd10, 64'd0);
        @(negedge clk);
        check("nondiv_stall", 64'(bus.div_stall), 64'd0);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("nondiv_ready", 64'(ready_cnt - r0), 64'd0);

        // Flush on the accept cycle blocks acceptance
        drive_op(OP_DIV, 64'd5, 64'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_accept_stall", 64'(bus.div_stall), 64'd0);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        check("flush_accept_wb", 64'(bus.wb_valid), 64'd0);

        // Flush during DONE suppresses wb_valid
        drive_op(OP_DIV, 64'd5, 64'd0);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b1;
        @(negedge clk);
        check("flush_done_wb", 64'(bus.wb_valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);

        // Flush mid-WAIT: old result dropped, queued DIV issues afterwards
        r0        = ready_cnt;
        model_lat = 40;
        model_res = 64'h0000_0000_0000_0BAD;
        drive_op(OP_DIV, 64'd50, 64'd5);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush       = 1'b0;
        bus.ex_valid    = 1'b1;
        bus.inst_opcode = OP_DIV;
        bus.rs1_data    = 64'hFFFF_FFFF_FFFF_FFB3;
        bus.rs2_data    = 64'd7;
        push_exp(64'hFFFF_FFFF_FFFF_FFF5, 1'b0);
        @(negedge clk);
        check("drain_stall", 64'(bus.div_stall), 64'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (ready_cnt == r0 + 2) break;
        end
        check("drain_reissue", 64'(ready_cnt - r0), 64'd2);
        model_res    = 64'hFFFF_FFFF_FFFF_FFF5;
        bus.ex_valid = 1'b0;
        wait_sb_empty(200);
        check("drain_new_dividend", cap_a, 64'hFFFF_FFFF_FFFF_FFB3);
        check("drain_new_divisor", cap_b, 64'd7);
        repeat (3) @(negedge clk);

        // Divider never answers: abort with div_err
        model_lat  = 5;
        model_hang = 1'b1;
        run_op("timeout", OP_DIVU, 64'd10, 64'd3, 0, 64'd0, 1'b1, 64'd10, 64'd3);
        check("err_hold", 64'(bus.div_err), 64'd1);
        model_hang = 1'b0;
        model_res  = 64'd33;
        run_op("err_clear", OP_DIVU, 64'd100, 64'd3, 0, 64'd33, 1'b0, 64'd100, 64'd3);

        // Asynchronous reset in the middle of WAIT
        model_hang = 1'b1;
        r0 = ready_cnt;
        drive_op(OP_DIVU, 64'd9, 64'd3);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("midwait_stall_before", 64'(bus.div_stall), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_stall", 64'(bus.div_stall), 64'd0);
        check("arst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("arst_ready", 64'(bus.div_ready), 64'd0);
        check("arst_err", 64'(bus.div_err), 64'd0);
        check("arst_wb_data", bus.wb_data, 64'd0);
        check("arst_dividend", bus.div_dividend, 64'd0);
        check("arst_divisor", bus.div_diviser, 64'd0);
        check("arst_opcode", 64'(bus.div_opcode), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_stall", 64'(bus.div_stall), 64'd0);
        check("post_rst_ready", 64'(ready_cnt - r0), 64'd1);
        model_hang = 1'b0;
        run_op("post_rst_by0", OP_REMU, 64'd77, 64'd0, 1, 64'd77, 1'b0, 64'd0, 64'd0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
